// File: rtl/alu_wb_if.sv
// alu_wb_if: bundles the ALU-result handshake and the register-file
// write port of the writeback stage.
//   master : upstream ALU / register-file side (drives results and rf_ack)
//   slave  : alu_wb_stage (drives in_ready and the rf write request)
// Signals:
//   in_valid/in_ready      result handshake
//   alu_out, addr_out      result data and destination address
//   alu_ot                 operation type (11 = no-op)
//   flag_we, za..lt        flag update enable and condition flags
//   rf_we/rf_ack           register-file write request / acknowledge
//   rf_waddr, rf_wdata     register-file write address and data
interface alu_wb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int RF_AW  = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] alu_out;
   logic [ADDR_W-1:0] addr_out;
   logic [1:0]        alu_ot;
   logic              flag_we;
   logic              za;
   logic              zb;
   logic              eq;
   logic              gt;
   logic              lt;
   logic              rf_we;
   logic [RF_AW-1:0]  rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              rf_ack;

   modport master (
      output in_valid, alu_out, addr_out, alu_ot, flag_we,
             za, zb, eq, gt, lt, rf_ack,
      input  in_ready, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  in_valid, alu_out, addr_out, alu_ot, flag_we,
             za, zb, eq, gt, lt, rf_ack,
      output in_ready, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: writeback stage behind the ALU. Accepted results are queued
// in a small FIFO and drained into the register-file write port; the stage
// also keeps the architectural flag register.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   bus         alu_wb_if.slave (result handshake + rf write port)
//   flags_q     registered flags {za,zb,eq,gt,lt}
//   wb_busy     FIFO not empty (pending writes, for hazard stalls)
//   addr_err    sticky: a result targeted an out-of-range register
//   wb_count    completed register writes, wraps at 16 bits
module alu_wb_stage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int RF_AW  = 4,
   parameter int DEPTH  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_wb_if.slave     bus,
   output logic [4:0]  flags_q,
   output logic        wb_busy,
   output logic        addr_err,
   output logic [15:0] wb_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int EW = RF_AW + DATA_W;
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          accept;
   logic          range_bad;
   logic          push;
   logic          pop;
   logic [EW-1:0] head;

   // in_ready depends on registered count only, so a pop while full does
   // not let a new result through in the same cycle.
   assign bus.in_ready = (count < DEPTH_C);
   assign bus.rf_we    = (count != '0);
   assign wb_busy      = (count != '0);

   assign accept    = bus.in_valid && bus.in_ready;
   assign range_bad = |bus.addr_out[ADDR_W-1:RF_AW];
   assign push      = accept && (bus.alu_ot != 2'b11) && !range_bad;
   assign pop       = bus.rf_we && bus.rf_ack;

   assign head         = mem[rd_ptr];
   assign bus.rf_waddr = bus.rf_we ? head[EW-1:DATA_W] : '0;
   assign bus.rf_wdata = bus.rf_we ? head[DATA_W-1:0]  : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         flags_q  <= '0;
         addr_err <= 1'b0;
         wb_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + PW'(1);
            wb_count <= wb_count + 16'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Flags follow issue order: they load at accept, even for
         // no-ops and dropped results.
         if (accept && bus.flag_we)
            flags_q <= {bus.za, bus.zb, bus.eq, bus.gt, bus.lt};
         if (accept && range_bad)
            addr_err <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {bus.addr_out[RF_AW-1:0], bus.alu_out};
   end
endmodule

// File: tb/tb_alu_wb_stage.sv
module tb_alu_wb_stage;
   logic        clk;
   logic        rst_n;
   logic [4:0]  flags_q;
   logic        wb_busy;
   logic        addr_err;
   logic [15:0] wb_count;

   alu_wb_if #(.DATA_W(16), .ADDR_W(16), .RF_AW(4)) bus ();

   alu_wb_stage #(.DATA_W(16), .ADDR_W(16), .RF_AW(4), .DEPTH(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .flags_q  (flags_q),
      .wb_busy  (wb_busy),
      .addr_err (addr_err),
      .wb_count (wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of {addr[3:0], data[15:0]} plus plain counters.
   logic [19:0] m_q [$];
   logic [4:0]  m_flags = '0;
   bit          m_err = 0;
   int          m_wbc = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_flags = '0;
         m_err   = 0;
         m_wbc   = 0;
      end else begin
         bit acc;
         acc = bus.in_valid && (m_q.size() < 2);
         if (m_q.size() > 0 && bus.rf_ack) begin
            void'(m_q.pop_front());
            m_wbc = (m_wbc + 1) % 65536;
         end
         if (acc) begin
            if (bus.flag_we)
               m_flags = {bus.za, bus.zb, bus.eq, bus.gt, bus.lt};
            if (bus.addr_out[15:4] != 0)
               m_err = 1;
            else if (bus.alu_ot != 2'b11)
               m_q.push_back({bus.addr_out[3:0], bus.alu_out});
         end
      end
   end

   // Log of writes the DUT actually completed, for order checks.
   logic [19:0] wr_log [$];

   always @(negedge clk) begin
      logic [19:0] h;
      h = (m_q.size() > 0) ? m_q[0] : 20'h0;
      chk("in_ready", bus.in_ready, (m_q.size() < 2));
      chk("rf_we",    bus.rf_we,    (m_q.size() != 0));
      chk("rf_waddr", bus.rf_waddr, h[19:16]);
      chk("rf_wdata", bus.rf_wdata, h[15:0]);
      chk("flags_q",  flags_q,      m_flags);
      chk("wb_busy",  wb_busy,      (m_q.size() != 0));
      chk("addr_err", addr_err,     m_err);
      chk("wb_count", wb_count,     m_wbc[15:0]);
      if (rst_n && bus.rf_we && bus.rf_ack)
         wr_log.push_back({bus.rf_waddr, bus.rf_wdata});
   end

   task automatic cyc(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_in(bit v, logic [1:0] ot, logic [15:0] a, logic [15:0] d,
                         bit fwe, logic [4:0] f);
      bus.in_valid = v;
      bus.alu_ot   = ot;
      bus.addr_out = a;
      bus.alu_out  = d;
      bus.flag_we  = fwe;
      {bus.za, bus.zb, bus.eq, bus.gt, bus.lt} = f;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.rf_ack = 1'b0;
      set_in(0, 2'b00, 16'h0, 16'h0, 0, 5'b0);
      cyc(2);
      chk("rst in_ready", bus.in_ready, 1);
      chk("rst rf_we", bus.rf_we, 0);
      chk("rst rf_wdata", bus.rf_wdata, 0);
      chk("rst wb_count", wb_count, 0);
      rst_n = 1'b1;
      cyc(1);

      // Single write
      set_in(1, 2'b01, 16'h0003, 16'h1234, 0, 5'b0);
      cyc(1);
      bus.in_valid = 1'b0;
      chk("t1 rf_we", bus.rf_we, 1);
      chk("t1 rf_waddr", bus.rf_waddr, 3);
      chk("t1 rf_wdata", bus.rf_wdata, 16'h1234);
      chk("t1 wb_busy", wb_busy, 1);
      bus.rf_ack = 1'b1;
      cyc(1);
      bus.rf_ack = 1'b0;
      chk("t1 rf_we after ack", bus.rf_we, 0);
      chk("t1 wb_count", wb_count, 1);

      // Full FIFO back-pressure: A, B accepted, C held
      wr_log.delete();
      set_in(1, 2'b01, 16'h0001, 16'hAAAA, 0, 5'b0);
      cyc(1);
      set_in(1, 2'b10, 16'h0002, 16'hBBBB, 0, 5'b0);
      cyc(1);
      set_in(1, 2'b00, 16'h0005, 16'hCCCC, 0, 5'b0);
      cyc(1);
      chk("abc full in_ready", bus.in_ready, 0);
      bus.rf_ack = 1'b1;
      cyc(1);
      bus.rf_ack = 1'b0;
      chk("abc in_ready after pop", bus.in_ready, 1);
      cyc(1);
      bus.in_valid = 1'b0;
      bus.rf_ack = 1'b1;
      cyc(3);
      bus.rf_ack = 1'b0;
      chk("abc write count", wr_log.size(), 3);
      if (wr_log.size() == 3) begin
         chk("abc w0", wr_log[0], 20'h1AAAA);
         chk("abc w1", wr_log[1], 20'h2BBBB);
         chk("abc w2", wr_log[2], 20'h5CCCC);
      end

      // Streaming, one write per cycle
      wr_log.delete();
      bus.rf_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_in(1, 2'b01, (i % 2) ? 16'h0006 : 16'h0009, 16'h0100 + 16'(i), 0, 5'b0);
         chk("stream in_ready", bus.in_ready, 1);
         cyc(1);
      end
      bus.in_valid = 1'b0;
      cyc(2);
      chk("stream wb_count", wb_count, 14);
      chk("stream writes", wr_log.size(), 10);
      for (int i = 0; i < 10 && i < wr_log.size(); i++)
         chk("stream order", wr_log[i],
             {((i % 2) ? 4'h6 : 4'h9), 16'h0100 + 16'(i)});

      // Out-of-range destination and no-op, both with flag updates
      set_in(1, 2'b01, 16'h0013, 16'hDEAD, 1, 5'b00100);
      cyc(1);
      bus.in_valid = 1'b0;
      chk("oor addr_err", addr_err, 1);
      chk("oor flags_q", flags_q, 5'b00100);
      chk("oor rf_we", bus.rf_we, 0);
      set_in(1, 2'b11, 16'h0004, 16'hBEEF, 1, 5'b00010);
      cyc(1);
      bus.in_valid = 1'b0;
      chk("noop flags_q", flags_q, 5'b00010);
      chk("noop rf_we", bus.rf_we, 0);
      chk("noop wb_count", wb_count, 14);
      set_in(1, 2'b01, 16'h0007, 16'h7777, 0, 5'b0);
      cyc(1);
      bus.in_valid = 1'b0;
      cyc(2);
      chk("sticky addr_err", addr_err, 1);
      chk("post wb_count", wb_count, 15);

      // Randomised traffic against the model
      for (int i = 0; i < 800; i++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(16, 65535))
                                          : 16'($urandom_range(0, 15));
         set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a,
                16'($urandom), $urandom_range(0, 1) == 1, 5'($urandom));
         bus.rf_ack = $urandom_range(0, 1) == 1;
         cyc(1);
      end

      // Reset mid-drain
      bus.rf_ack = 1'b0;
      bus.in_valid = 1'b0;
      cyc(3);
      bus.rf_ack = 1'b1;
      cyc(3);
      bus.rf_ack = 1'b0;
      set_in(1, 2'b01, 16'h0002, 16'h2222, 0, 5'b0);
      cyc(1);
      set_in(1, 2'b01, 16'h0004, 16'h4444, 0, 5'b0);
      cyc(1);
      bus.in_valid = 1'b0;
      bus.rf_ack = 1'b1;
      cyc(1);
      rst_n = 1'b0;
      #1;
      chk("rst mid rf_we", bus.rf_we, 0);
      chk("rst mid wb_busy", wb_busy, 0);
      cyc(1);
      bus.rf_ack = 1'b0;
      rst_n = 1'b1;
      cyc(1);
      chk("post rst wb_count", wb_count, 0);
      chk("post rst in_ready", bus.in_ready, 1);
      chk("post rst rf_we", bus.rf_we, 0);

      // wb_count wrap: 65535 streamed writes, then one more
      bus.rf_ack = 1'b1;
      set_in(1, 2'b01, 16'h0001, 16'h5A5A, 0, 5'b0);
      for (int i = 0; i < 65535; i++) begin
         bus.addr_out = 16'(i % 16);
         bus.alu_out  = 16'(i);
         cyc(1);
      end
      bus.in_valid = 1'b0;
      cyc(3);
      chk("wrap pre", wb_count, 16'hFFFF);
      set_in(1, 2'b10, 16'h000F, 16'hF00D, 0, 5'b0);
      cyc(1);
      bus.in_valid = 1'b0;
      cyc(2);
      bus.rf_ack = 1'b0;
      chk("wrap post", wb_count, 16'h0000);

      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
